// File: rtl/cartouche_loader.sv
// Cartridge write-side loader: turns the HPS ioctl download stream into byte writes to cartridge RAM.
// Optional padding of short images with FILL_BYTE is built when CARTOUCHE_FILL_EN is defined.
module cartouche_loader #(
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter logic [7:0] FILL_BYTE  = 8'hFF,
  parameter int         MEM_DEPTH  = 16384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        busy,
  output logic        cart_valid,
  output logic        cart_overflow,
  output logic [14:0] cart_size,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;

  localparam logic [14:0] DEPTH   = 15'(MEM_DEPTH);
  localparam logic [24:0] DEPTH_A = 25'(MEM_DEPTH);

  state_t      state;
  logic        dl_q;
  logic        match;
  logic        start;
  logic        stop;
  logic        in_range;
  logic [14:0] size_nxt;
`ifdef CARTOUCHE_FILL_EN
  localparam logic [14:0] LAST = 15'(MEM_DEPTH - 1);
  logic [14:0] fill_ptr;
`endif

  // Size never exceeds DEPTH because only in-range offsets reach this update.
  function automatic logic [14:0] size_update(input logic [14:0] cur, input logic [14:0] offs);
    logic [14:0] cand;
    cand = offs + 15'd1;
    if (cand > DEPTH) cand = DEPTH;
    return (cand > cur) ? cand : cur;
  endfunction

  function automatic logic [7:0] sum_wrap(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign match    = ioctl_download && (ioctl_index == CART_INDEX);
  assign start    = match && !dl_q;
  assign stop     = dl_q && !match;
  assign in_range = ioctl_addr < DEPTH_A;
  assign busy     = (state == LOAD) || (state == FILL);

  // Size including a strobe that lands in the same cycle as the download falling.
  always_comb begin
    size_nxt = cart_size;
    if (state == LOAD && ioctl_wr && in_range)
      size_nxt = size_update(cart_size, ioctl_addr[14:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      dl_q          <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_we        <= 1'b0;
      cart_valid    <= 1'b0;
      cart_overflow <= 1'b0;
      cart_size     <= '0;
      checksum      <= '0;
`ifdef CARTOUCHE_FILL_EN
      fill_ptr      <= '0;
`endif
    end else begin
      dl_q   <= match;
      mem_we <= 1'b0;
      case (state)
        IDLE: ;
        LOAD: begin
          if (ioctl_wr) begin
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= ioctl_addr[13:0];
              mem_din   <= ioctl_dout;
              checksum  <= sum_wrap(checksum, ioctl_dout);
              cart_size <= size_nxt;
            end else begin
              cart_overflow <= 1'b1;
            end
          end
          if (stop) begin
            if (size_nxt == 15'd0) state <= IDLE;
`ifdef CARTOUCHE_FILL_EN
            else if (size_nxt < DEPTH) begin
              state    <= FILL;
              fill_ptr <= size_nxt;
            end
`endif
            else state <= DONE;
          end
        end
        FILL: begin
`ifdef CARTOUCHE_FILL_EN
          mem_we   <= 1'b1;
          mem_addr <= fill_ptr[13:0];
          mem_din  <= FILL_BYTE;
          fill_ptr <= fill_ptr + 15'd1;
          if (fill_ptr == LAST) state <= DONE;
`else
          state <= IDLE;
`endif
        end
        DONE:    cart_valid <= 1'b1;
        default: state <= IDLE;
      endcase
      // A new start overrides whatever the current state decided, after its write completes.
      if (start) begin
        state         <= LOAD;
        cart_size     <= '0;
        checksum      <= '0;
        cart_overflow <= 1'b0;
        cart_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cartouche_loader.sv
// Bench for cartouche_loader: table-driven image load, scoreboard of expected memory writes,
// and hand-written sequences for overflow, foreign index, restart, empty download and reset.
module tb_cartouche_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [13:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        busy;
  logic        cart_valid;
  logic        cart_overflow;
  logic [14:0] cart_size;
  logic [7:0]  checksum;

  cartouche_loader dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .busy(busy), .cart_valid(cart_valid), .cart_overflow(cart_overflow),
    .cart_size(cart_size), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];
  logic [21:0] exp_e;
  int fill_next = 0;
  int fill_end  = 0;

  logic       m_loading = 1'b0;
  int         m_size = 0;
  logic [7:0] m_sum = 8'd0;
  logic       m_ovf = 1'b0;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_sum;
    int          exp_size;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Every write the DUT issues is either the next expected pad byte or the head of the queue.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      checks++;
      if (fill_next < fill_end && int'(mem_addr) == fill_next && mem_din == 8'hFF) begin
        fill_next++;
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=0x%0h din=0x%0h with nothing expected", mem_addr, mem_din);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e != {mem_addr, mem_din}) begin
          errors++;
          $display("FAIL write_order: got addr=0x%0h din=0x%0h expected addr=0x%0h din=0x%0h",
                   mem_addr, mem_din, exp_e[21:8], exp_e[7:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_end;
    if (m_loading) begin
      m_loading = 1'b0;
`ifdef CARTOUCHE_FILL_EN
      if (m_size > 0 && m_size < 16384) begin
        fill_next = m_size;
        fill_end  = 16384;
      end
`endif
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 8'd1) begin
      m_loading = 1'b1;
      m_size    = 0;
      m_sum     = 8'd0;
      m_ovf     = 1'b0;
    end
    tick();
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input logic fall);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (m_loading) begin
      if (a < 25'd16384) begin
        exp_q.push_back({a[13:0], d});
        m_sum = m_sum + d;
        if (int'(a) + 1 > m_size) m_size = int'(a) + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (fall) begin
      ioctl_download = 1'b0;
      model_end();
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl;
    ioctl_download = 1'b0;
    model_end();
    tick();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!cart_valid && n < 20000) begin
      tick();
      n++;
    end
    chk(name, int'(cart_valid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{25'd0, 8'h12, 8'h12, 1};
    vecs[1] = '{25'd1, 8'h34, 8'h46, 2};
    vecs[2] = '{25'd2, 8'h56, 8'h9C, 3};
    vecs[3] = '{25'd3, 8'h78, 8'h14, 4};

    // Reset held with an active download and strobes.
    reset_n = 1'b0; ioctl_download = 1'b1; ioctl_index = 8'd1; ioctl_wr = 1'b1; ioctl_dout = 8'hA5;
    repeat (3) tick();
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_din", int'(mem_din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(cart_valid), 0);
    chk("rst_overflow", int'(cart_overflow), 0);
    chk("rst_size", int'(cart_size), 0);
    chk("rst_checksum", int'(checksum), 0);
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0; reset_n = 1'b1;
    tick(); tick();
    chk("idle_busy", int'(busy), 0);

    // 4-byte image from the table, back-to-back strobes.
    start_dl(8'd1);
    chk("load_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].addr, vecs[i].data, 1'b0);
      chk($sformatf("tbl%0d_we", i), int'(mem_we), 1);
      chk($sformatf("tbl%0d_addr", i), int'(mem_addr), int'(vecs[i].addr));
      chk($sformatf("tbl%0d_din", i), int'(mem_din), int'(vecs[i].data));
      chk($sformatf("tbl%0d_sum", i), int'(checksum), int'(vecs[i].exp_sum));
      chk($sformatf("tbl%0d_size", i), int'(cart_size), vecs[i].exp_size);
    end
    end_dl();
`ifdef CARTOUCHE_FILL_EN
    chk("fill_busy", int'(busy), 1);
    wait_valid("img4_valid");
    chk("img4_fill_count", fill_next, 16384);
`else
    chk("img4_valid_early", int'(cart_valid), 0);
    tick();
    chk("img4_valid", int'(cart_valid), 1);
`endif
    chk("img4_busy", int'(busy), 0);
    chk("img4_sum", int'(checksum), 8'h14);
    chk("img4_size", int'(cart_size), 4);
    chk("img4_ovf", int'(cart_overflow), 0);

    // Foreign index is ignored entirely.
    start_dl(8'd2);
    for (int i = 0; i < 4; i++) send(25'(i), 8'hE0 + 8'(i), 1'b0);
    end_dl();
    repeat (4) tick();
    chk("idx2_valid", int'(cart_valid), 1);
    chk("idx2_sum", int'(checksum), 8'h14);
    chk("idx2_size", int'(cart_size), 4);
    chk("idx2_busy", int'(busy), 0);

    // 16385-byte image: last byte out of range.
    start_dl(8'd1);
    for (int i = 0; i <= 16384; i++) send(25'(i), 8'(i * 7 + 3), 1'b0);
    end_dl();
    wait_valid("ovf_valid");
    chk("ovf_flag", int'(cart_overflow), 1);
    chk("ovf_size", int'(cart_size), 16384);
    chk("ovf_sum", int'(checksum), int'(m_sum));
    chk("ovf_queue", exp_q.size(), 0);

`ifdef CARTOUCHE_FILL_EN
    // Short image, then a new download starts while padding is under way.
    start_dl(8'd1);
    send(25'd0, 8'hAA, 1'b0);
    send(25'd1, 8'h55, 1'b0);
    end_dl();
    repeat (10) tick();
    chk("abort_fill_running", int'(busy), 1);
    fill_end = fill_next + 2;
`endif
    start_dl(8'd1);
    chk("restart_valid", int'(cart_valid), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_size", int'(cart_size), 0);
    chk("restart_sum", int'(checksum), 0);
    chk("restart_ovf", int'(cart_overflow), 0);
    repeat (3) tick();
    send(25'd0, 8'h11, 1'b0);
    send(25'd1, 8'h22, 1'b0);
    send(25'd2, 8'h33, 1'b1);
    chk("fall_strobe_we", int'(mem_we), 1);
    chk("fall_strobe_addr", int'(mem_addr), 2);
    wait_valid("restart_done");
`ifdef CARTOUCHE_FILL_EN
    chk("restart_fill_count", fill_next, 16384);
`endif
    chk("restart_size3", int'(cart_size), 3);
    chk("restart_sum3", int'(checksum), 8'h66);

    // Download pulse with no strobes.
    start_dl(8'd1);
    end_dl();
    repeat (4) tick();
    chk("empty_valid", int'(cart_valid), 0);
    chk("empty_busy", int'(busy), 0);
    chk("empty_size", int'(cart_size), 0);
    chk("empty_sum", int'(checksum), 0);
    chk("queue_drained", exp_q.size(), 0);

    // Reset mid-load drops the write strobe at once.
    start_dl(8'd1);
    send(25'd5, 8'hC3, 1'b0);
    chk("pre_rst_we", int'(mem_we), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_we", int'(mem_we), 0);
    chk("async_rst_size", int'(cart_size), 0);
    chk("async_rst_sum", int'(checksum), 0);
    chk("async_rst_busy", int'(busy), 0);
    exp_q.delete();
    ioctl_download = 1'b0;
    m_loading = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cartouche_loader.md
# cartouche_loader

Write-side front end for the MO cartridge memory. Accepts the MiSTer HPS file-download byte stream (ioctl bus), validates and bounds-checks it, and drives the cartridge memory write port (addr_wr / din / we) one byte per cycle. It also tracks image size and checksum, and optionally pads unused space with a fill byte. Sits between hps_io and the cartridge memory; the CPU-side read port is untouched.

## Interface

Parameters:
- CART_INDEX, 8'd1, ioctl_index value identifying a cartridge image
- FILL_BYTE, 8'hFF, pad value written after a short image
- MEM_DEPTH, 16384, cartridge size in bytes (power of two, ≤16384)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset_n  in  1  reset, asynchronous, active-low
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  download file index
- ioctl_wr  in  1  one-cycle strobe, byte valid
- ioctl_addr  in  25  byte offset within the file
- ioctl_dout  in  8  download byte
- mem_addr  out  14  memory write address
- mem_din  out  8  memory write data
- mem_we  out  1  memory write enable, one cycle per byte
- busy  out  1  high in LOAD or FILL
- cart_valid  out  1  a non-empty image is fully loaded
- cart_overflow  out  1  image exceeded MEM_DEPTH
- cart_size  out  15  highest written offset + 1, 0..16384
- checksum  out  8  mod-256 sum of accepted bytes

## Operation

- `match` = ioctl_download & (ioctl_index == CART_INDEX). A start is a 0→1 of `match`, registered `dl_q` vs current.
- States: IDLE, LOAD, FILL, DONE. Encoding is free; the FSM has no illegal-state lockup, and unused codes go to IDLE.
- IDLE/DONE/FILL → LOAD on a start. On entry: cart_size=0, checksum=0, cart_overflow=0, cart_valid=0. A FILL in progress is aborted.
- LOAD, per ioctl_wr:
  - If ioctl_addr < MEM_DEPTH: write ioctl_dout at ioctl_addr[13:0], checksum += byte, cart_size = max(cart_size, ioctl_addr+1).
  - Otherwise: set cart_overflow, no write, checksum unchanged.
- LOAD exit on `match` falling:
  - cart_size==0 → IDLE.
  - Fill compiled in and cart_size<MEM_DEPTH → FILL, fill pointer = cart_size.
  - Otherwise → DONE.
- FILL: one write of FILL_BYTE per cycle, pointer+1. After address MEM_DEPTH-1 is written → DONE. Fill writes do not touch checksum or cart_size.
- DONE: cart_valid=1. Held until the next start or reset.
- Downloads with another index are ignored in every state, and outputs are unchanged.
- ioctl_wr outside LOAD is ignored.

## Timing

- Reset values: mem_addr=0, mem_din=0, mem_we=0, busy=0, cart_valid=0, cart_overflow=0, cart_size=0, checksum=0, state IDLE.
- Write latency: ioctl_wr at cycle N → mem_we=1 with registered addr/data at N+1, low at N+2 unless another byte arrives. Back-to-back strobes give back-to-back writes. No backpressure.
- A strobe in the same cycle as download falls is accepted. The state change takes effect after that write; the first FILL write comes at N+2 at the earliest.
- A start seen in the same cycle as the last FILL write wins: that write completes, and the next state is LOAD.
- Counters: cart_size is 15-bit and saturates at MEM_DEPTH; checksum wraps mod 256; fill pointer is 15-bit, compared against MEM_DEPTH.
- Reset mid-LOAD or mid-FILL: mem_we drops immediately (asynchronously) and all outputs take their reset values. Memory contents are not cleared.

## Configuration

- CARTOUCHE_FILL_EN defined: the FILL state exists. A short image is padded with FILL_BYTE up to MEM_DEPTH-1, so stale data from a previous cartridge is erased. busy covers the fill time.
- Not defined: FILL is not built. LOAD goes straight to DONE, and bytes beyond cart_size keep their previous contents.

## Test plan

- Reset: hold reset_n=0 with strobes active → all outputs 0, no mem_we. Release → IDLE.
- 4-byte image, index 1, bytes 12 34 56 78 at addr 0..3 → mem_we at addresses 0..3 one cycle after each strobe, checksum=0x14, cart_size=4.
  - With CARTOUCHE_FILL_EN: 16380 writes of 0xFF at addresses 4..16383, then cart_valid=1.
  - Without: cart_valid=1 two cycles after download falls.
- 16385-byte image → 16384 writes, last at 0x3FFF. Byte at offset 16384 not written, cart_overflow=1, cart_size=16384, no FILL.
- Download with index 2 (4 bytes) → no mem_we, cart_valid and checksum unchanged from the prior load.
- Start new index-1 download mid-FILL → FILL aborts within one cycle, cart_valid=0, new bytes written from the new addr 0, size and checksum recomputed.
- Empty download (download pulse with no strobes) → state returns to IDLE, cart_valid=0, no writes.
